// File: rtl/present_core_if.sv
// present_core_if: request/result bundle for present_core.
interface present_core_if #(parameter int KEY_W = 80);
    logic             start;
    logic             mode;
    logic [63:0]      din;
    logic [KEY_W-1:0] key;
    logic             ready;
    logic             busy;
    logic [4:0]       cnt;
    logic [63:0]      dout;
    modport master (output start, mode, din, key, input ready, busy, cnt, dout);
    modport slave (input start, mode, din, key, output ready, busy, cnt, dout);
endinterface

// File: rtl/present_core.sv
// present_core: iterative PRESENT-64 cipher, one round per cycle; define PRESENT_DEC_EN to add decryption.
module present_core #(
    parameter int KEY_W = 80
) (
    input logic           CK,
    input logic           RN,
    present_core_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, KEYEXP = 2'd1, ROUND = 2'd2, DONE = 2'd3;
    localparam logic [63:0] SB = 64'h21748FE3DA09B65C;
    localparam int XP = (KEY_W == 80) ? 15 : 62;

    generate
        if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
            $error("present_core: KEY_W must be 80 or 128");
        end
    endgenerate

    function automatic logic [3:0] sb4(input logic [3:0] n, input logic [63:0] t);
        return t[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sub(input logic [63:0] x, input logic [63:0] t);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[6'(4 * i) +: 4] = sb4(x[6'(4 * i) +: 4], t);
        return r;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] x);
        logic [63:0] r;
        r[63] = x[63];
        for (int i = 0; i < 63; i++) r[6'((16 * i) % 63)] = x[6'(i)];
        return r;
    endfunction

    logic [1:0]       st;
    logic [63:0]      state;
    logic [KEY_W-1:0] kreg;
    logic [KEY_W-1:0] kf;
    logic [4:0]       cnt;
    logic [63:0]      dout;
    logic             ready;
    logic             busy;
    logic [63:0]      rk;
    logic [63:0]      enc_next;

    assign busy     = (st == ROUND) || (st == KEYEXP);
    assign rk       = kreg[KEY_W-1 -: 64];
    assign enc_next = perm(sub(state ^ rk, SB));

    // forward schedule step: cnt is the index of the key being replaced
    always_comb begin
        kf = {kreg[KEY_W-62:0], kreg[KEY_W-1:KEY_W-61]};
        kf[KEY_W-1 -: 4] = sb4(kf[KEY_W-1 -: 4], SB);
        if (KEY_W == 128) kf[KEY_W-5 -: 4] = sb4(kf[KEY_W-5 -: 4], SB);
        kf[XP +: 5] = kf[XP +: 5] ^ cnt;
    end

`ifdef PRESENT_DEC_EN
    localparam logic [63:0] SBI = 64'hA970364BD21C8FE5;

    function automatic logic [63:0] iperm(input logic [63:0] x);
        logic [63:0] r;
        r[63] = x[63];
        for (int i = 0; i < 63; i++) r[6'(i)] = x[6'((16 * i) % 63)];
        return r;
    endfunction

    logic             md;
    logic [KEY_W-1:0] kt;
    logic [KEY_W-1:0] kb;
    logic [63:0]      dec_next;

    assign dec_next = sub(iperm(state ^ rk), SBI);

    always_comb begin
        kt = kreg;
        kt[XP +: 5] = kt[XP +: 5] ^ cnt;
        kt[KEY_W-1 -: 4] = sb4(kt[KEY_W-1 -: 4], SBI);
        if (KEY_W == 128) kt[KEY_W-5 -: 4] = sb4(kt[KEY_W-5 -: 4], SBI);
        kb = {kt[60:0], kt[KEY_W-1:61]};
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
`endif

    // ROUND with cnt==0 is the final whitening step in both directions
    always_ff @(posedge CK) begin
        if (!RN) begin
            st    <= IDLE;
            state <= '0;
            kreg  <= '0;
            cnt   <= '0;
            dout  <= '0;
            ready <= 1'b0;
`ifdef PRESENT_DEC_EN
            md    <= 1'b0;
`endif
        end else if (!busy) begin
            if (bus.start) begin
                state <= bus.din;
                kreg  <= bus.key;
                cnt   <= 5'd1;
                ready <= 1'b0;
`ifdef PRESENT_DEC_EN
                md    <= bus.mode;
                st    <= bus.mode ? KEYEXP : ROUND;
`else
                st    <= ROUND;
`endif
            end
        end else if (st == ROUND) begin
            if (cnt == 5'd0) begin
                dout  <= state ^ rk;
                ready <= 1'b1;
                st    <= DONE;
            end
`ifdef PRESENT_DEC_EN
            else if (md) begin
                state <= dec_next;
                kreg  <= kb;
                cnt   <= cnt - 5'd1;
            end
`endif
            else begin
                state <= enc_next;
                kreg  <= kf;
                cnt   <= cnt + 5'd1;
            end
        end
`ifdef PRESENT_DEC_EN
        else begin
            kreg <= kf;
            cnt  <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
            st   <= (cnt == 5'd31) ? ROUND : KEYEXP;
        end
`endif
    end

    assign bus.ready = ready;
    assign bus.busy  = busy;
    assign bus.cnt   = cnt;
    assign bus.dout  = dout;
endmodule

// File: tb/tb_present_core.sv
// tb_present_core: directed known-answer, latency, abort and reset checks for present_core.
module tb_present_core;
    logic CK = 1'b0;
    logic RN = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 CK = ~CK;

    present_core_if #(.KEY_W(80))  i80 ();
    present_core_if #(.KEY_W(128)) i128 ();

    present_core #(.KEY_W(80))  u80  (.CK(CK), .RN(RN), .bus(i80));
    present_core #(.KEY_W(128)) u128 (.CK(CK), .RN(RN), .bus(i128));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit w, input bit m, input logic [63:0] d, input logic [127:0] k);
        if (w) begin
            i128.start = 1'b1; i128.mode = m; i128.din = d; i128.key = k;
        end else begin
            i80.start = 1'b1; i80.mode = m; i80.din = d; i80.key = k[79:0];
        end
        @(posedge CK); #1;
        i80.start = 1'b0;
        i128.start = 1'b0;
    endtask

    task automatic finish_op(input bit w, input int pulse_at, output logic [63:0] res,
                             output int lat, output int bc, output bit stable);
        logic [63:0] d0;
        d0 = w ? i128.dout : i80.dout;
        lat = 0;
        bc = 0;
        stable = 1'b1;
        while (lat < 200) begin
            @(posedge CK); #1;
            i80.start = 1'b0;
            i128.start = 1'b0;
            lat++;
            if (w ? i128.ready : i80.ready) break;
            if (w ? i128.busy : i80.busy) bc++;
            if ((w ? i128.dout : i80.dout) !== d0) stable = 1'b0;
            if (lat == pulse_at) begin
                if (w) begin i128.start = 1'b1; i128.din = '1; end
                else begin i80.start = 1'b1; i80.din = '1; end
            end
        end
        res = w ? i128.dout : i80.dout;
    endtask

    task automatic run(input string tag, input bit w, input bit m, input logic [63:0] d,
                       input logic [127:0] k, input int pulse_at, input logic [63:0] exp,
                       input int exp_lat);
        logic [63:0] res;
        int lat;
        int bc;
        bit stable;
        go(w, m, d, k);
        finish_op(w, pulse_at, res, lat, bc, stable);
        chk({tag, " dout"}, res, exp);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(bc), 64'(exp_lat - 1));
        chk({tag, " dout stable in flight"}, 64'(stable), 64'd1);
        chk({tag, " cnt in DONE"}, 64'(w ? i128.cnt : i80.cnt), 64'd0);
    endtask

    initial begin
        i80.start = 1'b0;  i80.mode = 1'b0;  i80.din = '0;  i80.key = '0;
        i128.start = 1'b0; i128.mode = 1'b0; i128.din = '0; i128.key = '0;
        repeat (2) @(posedge CK);
        #1;
        chk("reset ready", 64'(i80.ready), 64'd0);
        chk("reset busy", 64'(i80.busy), 64'd0);
        chk("reset cnt", 64'(i80.cnt), 64'd0);
        chk("reset dout", i80.dout, 64'd0);
        chk("reset dout 128", i128.dout, 64'd0);
        RN = 1'b1;

        run("enc80 zero", 0, 0, 64'h0, 128'h0, 0, 64'h5579C1387B228445, 32);
        run("enc80 ones", 0, 0, '1, {128{1'b1}}, 0, 64'h3333DCD3213210D2, 32);
        run("enc80 key ones", 0, 0, 64'h0, {128{1'b1}}, 0, 64'hE72C46C0F5945049, 32);

        repeat (5) @(posedge CK);
        #1;
        chk("DONE hold dout", i80.dout, 64'hE72C46C0F5945049);
        chk("DONE hold ready", 64'(i80.ready), 64'd1);
        chk("DONE hold cnt", 64'(i80.cnt), 64'd0);

        run("enc80 start ignored", 0, 0, 64'h0, 128'h0, 10, 64'h5579C1387B228445, 32);

        go(0, 0, '1, {128{1'b1}});
        repeat (19) @(posedge CK);
        #1;
        chk("mid-op busy", 64'(i80.busy), 64'd1);
        RN = 1'b0;
        @(posedge CK); #1;
        chk("abort ready", 64'(i80.ready), 64'd0);
        chk("abort busy", 64'(i80.busy), 64'd0);
        chk("abort cnt", 64'(i80.cnt), 64'd0);
        chk("abort dout", i80.dout, 64'd0);
        RN = 1'b1;
        run("enc80 after abort", 0, 0, '1, {128{1'b1}}, 0, 64'h3333DCD3213210D2, 32);

        RN = 1'b0;
        i80.start = 1'b1; i80.din = 64'h0; i80.key = '0;
        @(posedge CK); #1;
        RN = 1'b1;
        i80.start = 1'b0;
        @(posedge CK); #1;
        chk("start in reset busy", 64'(i80.busy), 64'd0);
        chk("start in reset ready", 64'(i80.ready), 64'd0);
        chk("start in reset dout", i80.dout, 64'd0);

`ifdef PRESENT_DEC_EN
        run("dec80 zero key", 0, 1, 64'h5579C1387B228445, 128'h0, 0, 64'h0, 63);
        run("enc128 zero", 1, 0, 64'h0, 128'h0, 0, 64'h96DB702A2E6900AF, 32);
        run("dec128 zero key", 1, 1, 64'h96DB702A2E6900AF, 128'h0, 0, 64'h0, 63);
`else
        run("enc80 mode ignored", 0, 1, 64'h0, 128'h0, 0, 64'h5579C1387B228445, 32);
        run("enc128 zero", 1, 0, 64'h0, 128'h0, 0, 64'h96DB702A2E6900AF, 32);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
